// File: rtl/shift_issue_stage.sv
// Decode-to-execute issue stage for the 16-bit barrel shifter: decodes shift/rotate
// instructions and queues the operands in a 2-entry registered FIFO (main + skid).
//
// state | meaning
// EMPTY | no entries held, out_valid = 0
// ONE   | one entry held, can accept and issue
// FULL  | two entries held, in_ready = 0
module shift_issue_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sh_in,
  output logic [3:0]        sh_cnt,
  output logic [1:0]        sh_op,
  output logic [REG_W-1:0]  out_rd,
  output logic              illegal
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state_q, state_d;

  logic              is_imm, is_reg, legal;
  logic [3:0]        dec_cnt;
  logic [1:0]        dec_op;
  logic [REG_W-1:0]  dec_rd;
  logic              enq, deq;
  logic              wr_ptr, rd_ptr;

  logic [DATA_W-1:0] in_mem  [2];
  logic [3:0]        cnt_mem [2];
  logic [1:0]        op_mem  [2];
  logic [REG_W-1:0]  rd_mem  [2];

  logic unused_bits;
  assign unused_bits = ^{in_instr[10:8], in_rt_data[DATA_W-1:4]};

  // Opcodes 10100..10111 are immediate shifts; 11010 is the register-count form.
  always_comb begin
    is_imm  = (in_instr[15:13] == 3'b101);
    is_reg  = (in_instr[15:11] == 5'b11010);
    legal   = is_imm | is_reg;
    dec_cnt = in_instr[3:0];
    dec_op  = in_instr[12:11];
    dec_rd  = in_instr[7:5];
    if (is_reg) begin
      dec_cnt = in_rt_data[3:0];
      dec_op  = in_instr[1:0];
      dec_rd  = in_instr[4:2];
    end
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign enq       = in_valid & in_ready & legal;
  assign deq       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (enq) state_d = ONE;
        ONE: begin
          if (enq && !deq)      state_d = FULL;
          else if (deq && !enq) state_d = EMPTY;
        end
        FULL:    if (deq) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        in_mem[i]  <= '0;
        cnt_mem[i] <= '0;
        op_mem[i]  <= '0;
        rd_mem[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (enq) begin
        in_mem[wr_ptr]  <= in_rs_data;
        cnt_mem[wr_ptr] <= dec_cnt;
        op_mem[wr_ptr]  <= dec_op;
        rd_mem[wr_ptr]  <= dec_rd;
        wr_ptr          <= ~wr_ptr;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      illegal <= in_valid & in_ready & ~legal;
    end
  end

  assign sh_in  = in_mem[rd_ptr];
  assign sh_cnt = cnt_mem[rd_ptr];
  assign sh_op  = op_mem[rd_ptr];
  assign out_rd = rd_mem[rd_ptr];

endmodule

// File: tb/tb_shift_issue_stage.sv
// Self-checking bench for shift_issue_stage: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [15:0] in_instr, in_rs_data, in_rt_data, sh_in;
  logic [3:0]  sh_cnt;
  logic [1:0]  sh_op;
  logic [2:0]  out_rd;

  shift_issue_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .sh_in(sh_in), .sh_cnt(sh_cnt), .sh_op(sh_op), .out_rd(out_rd),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [1:0]  op;
    logic [2:0]  rd;
  } entry_t;

  entry_t mq[$];
  logic   exp_illegal = 1'b0;
  logic   zero_outs   = 1'b0;
  logic   chk_en      = 1'b0;
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: classify by opcode value and build the operand record directly.
  function automatic bit model_decode(input logic [15:0] ins, input logic [15:0] rs,
                                      input logic [15:0] rt, output entry_t e);
    int opc;
    opc    = int'(ins >> 11);
    e.data = rs;
    if (opc >= 20 && opc <= 23) begin
      e.op  = 2'(opc - 20);
      e.cnt = 4'(ins % 16);
      e.rd  = 3'((ins / 32) % 8);
      return 1'b1;
    end else if (opc == 26) begin
      e.op  = 2'(ins % 4);
      e.cnt = 4'(rt % 16);
      e.rd  = 3'((ins / 4) % 8);
      return 1'b1;
    end
    e.op = 0; e.cnt = 0; e.rd = 0;
    return 1'b0;
  endfunction

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] rs,
                      input logic [15:0] rt, input logic ordy, input logic fl,
                      input logic rs_t);
    entry_t e;
    bit     lg, acc, dq;
    @(negedge clk);
    in_valid = v; in_instr = ins; in_rs_data = rs; in_rt_data = rt;
    out_ready = ordy; flush = fl; rst = rs_t;
    lg  = model_decode(ins, rs, rt, e);
    acc = v && (mq.size() < 2);
    dq  = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (rs_t) begin
      mq.delete(); exp_illegal = 1'b0; zero_outs = 1'b1;
    end else if (fl) begin
      mq.delete(); exp_illegal = 1'b0;
    end else begin
      if (dq) void'(mq.pop_front());
      if (acc && lg) begin
        mq.push_back(e); zero_outs = 1'b0;
      end
      exp_illegal = acc && !lg;
    end
    chk_en = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("illegal", 32'(illegal), 32'(exp_illegal));
      if (mq.size() > 0) begin
        chk("sh_in", 32'(sh_in), 32'(mq[0].data));
        chk("sh_cnt", 32'(sh_cnt), 32'(mq[0].cnt));
        chk("sh_op", 32'(sh_op), 32'(mq[0].op));
        chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
      end else if (zero_outs) begin
        chk("zero_after_rst", 32'({sh_in, sh_cnt, sh_op, out_rd}), 32'd0);
      end
    end
  end

  localparam logic [15:0] A_I = 16'hA8A5;
  localparam logic [15:0] B_I = 16'hD00F;
  localparam logic [15:0] C_I = 16'hB063;

  initial begin
    logic [15:0] ins;
    rst = 1'b1; in_valid = 0; in_instr = 0; in_rs_data = 0; in_rt_data = 0;
    out_ready = 0; flush = 0;

    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sh_in", 32'(sh_in), 0);

    step(1, A_I, 16'h1234, 16'h0000, 1, 0, 0);
    #2;
    chk("slli_valid", 32'(out_valid), 1);
    chk("slli_sh_in", 32'(sh_in), 32'h1234);
    chk("slli_cnt", 32'(sh_cnt), 5);
    chk("slli_op", 32'(sh_op), 1);
    chk("slli_rd", 32'(out_rd), 5);

    step(1, B_I, 16'h8000, 16'hFFF9, 1, 0, 0);
    #2;
    chk("srl_cnt", 32'(sh_cnt), 9);
    chk("srl_op", 32'(sh_op), 3);
    chk("srl_rd", 32'(out_rd), 3);
    step(0, 0, 0, 0, 1, 0, 0);

    // Backpressure: A, B fill the queue; C is refused until space frees up.
    step(1, A_I, 16'h000A, 16'h0, 0, 0, 0);
    step(1, B_I, 16'h000B, 16'h2, 0, 0, 0);
    #2;
    chk("bp_in_ready_c", 32'(in_ready), 0);
    step(1, C_I, 16'h000C, 16'h0, 0, 0, 0);
    #2;
    chk("bp_hold_a", 32'(sh_in), 32'h000A);
    step(1, C_I, 16'h000C, 16'h0, 1, 0, 0);
    #2;
    chk("drain_b", 32'(sh_in), 32'h000B);
    step(1, C_I, 16'h000C, 16'h0, 1, 0, 0);
    #2;
    chk("drain_c", 32'(sh_in), 32'h000C);
    step(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("drain_empty", 32'(out_valid), 0);

    step(1, A_I, 16'h1111, 0, 0, 0, 0);
    step(1, C_I, 16'h2222, 0, 0, 0, 0);
    step(1, A_I, 16'h3333, 0, 0, 1, 0);
    #2;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);

    step(1, A_I, 16'h5555, 0, 0, 0, 0);
    step(1, 16'h4000, 16'h6666, 0, 0, 0, 0);
    #2;
    chk("illegal_pulse", 32'(illegal), 1);
    step(1, B_I, 16'h7777, 16'h0004, 0, 0, 0);
    #2;
    chk("illegal_clear", 32'(illegal), 0);
    chk("illegal_head", 32'(sh_in), 32'h5555);
    step(0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("illegal_second", 32'(sh_in), 32'h7777);
    chk("illegal_second_cnt", 32'(sh_cnt), 4);

    step(1, A_I, 16'h9999, 0, 0, 0, 0);
    #2;
    chk("prerst_full", 32'(in_ready), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_sh_in", 32'(sh_in), 0);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: ins = {3'b101, 13'($urandom)};
        1: ins = {5'b11010, 11'($urandom)};
        2: ins = {3'b110, 2'b10, 11'($urandom)};
        default: ins = 16'($urandom);
      endcase
      step(($urandom_range(0, 3) != 0), ins, 16'($urandom), 16'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 150) == 0));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
